// File: rtl/dmem_responder.sv
// Single-port data-memory responder for the MEM-stage d_m_* bus: one-cycle hit pulse, registered read data, byte-masked writes.
// Define DMEM_WAIT_STATES_EN to compile in the WAIT state and its 4-bit down-counter (WAIT_CYCLES stall cycles per request).
module dmem_responder #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   d_m_addr_i,
  input  logic                    d_m_rden_i,
  input  logic                    d_m_wren_i,
  input  logic [DATA_WIDTH/8-1:0] d_m_wmask_i,
  input  logic [DATA_WIDTH-1:0]   d_m_wdata_i,
  output logic                    d_m_hit_o,
  output logic [DATA_WIDTH-1:0]   d_m_rdata_o,
  output logic                    d_m_err_o
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFSET = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);

`ifdef DMEM_WAIT_STATES_EN
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  logic [3:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE, RESP} state_t;
  logic unused_cfg;
  assign unused_cfg = (WAIT_CYCLES > 15);
`endif

  state_t                  state_q, state_d;
  logic                    access;
  logic                    req;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [ADDR_WIDTH-1:0]   word;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  // Live request lines are decoded at the access edge, so changes made during WAIT take effect.
  assign req      = d_m_rden_i | d_m_wren_i;
  assign offset   = d_m_addr_i - BASE_ADDR;
  assign word     = offset >> OFFSET;
  assign in_range = (d_m_addr_i >= BASE_ADDR) && (word < ADDR_WIDTH'(DEPTH_WORDS));
  assign idx      = word[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    access  = 1'b0;
`ifdef DMEM_WAIT_STATES_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
`ifdef DMEM_WAIT_STATES_EN
          if (WAIT_LD != 4'd0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LD;
          end else
`endif
          begin
            access  = 1'b1;
            state_d = RESP;
          end
        end
      end
`ifdef DMEM_WAIT_STATES_EN
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          // The counter hits zero on this edge, which is the access edge.
          access  = 1'b1;
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_WAIT_STATES_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef DMEM_WAIT_STATES_EN
      cnt_q   <= cnt_d;
`endif
      if (access) begin
        err_q   <= !in_range;
        rdata_q <= (in_range && !d_m_wren_i) ? mem[idx] : '0;
      end
    end
  end

  // Array is deliberately not reset; the write is gated by rst_i so a pending write is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && access && d_m_wren_i && in_range) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (d_m_wmask_i[b]) mem[idx][8*b +: 8] <= d_m_wdata_i[8*b +: 8];
      end
    end
  end

  assign d_m_hit_o   = (state_q == RESP);
  assign d_m_rdata_o = rdata_q;
  assign d_m_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected responses from a word-level reference model, monitor checks each hit.
module tb_dmem_responder;

`ifdef DMEM_WAIT_STATES_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif
  localparam int DEPTH = 1024;
  localparam int WIN   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        rden = 1'b0;
  logic        wren = 1'b0;
  logic [3:0]  wmask = '0;
  logic [31:0] wdata = '0;
  logic        hit;
  logic [31:0] rdata;
  logic        err;

  dmem_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (32'h0),
    .WAIT_CYCLES(3)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .d_m_addr_i (addr),
    .d_m_rden_i (rden),
    .d_m_wren_i (wren),
    .d_m_wmask_i(wmask),
    .d_m_wdata_i(wdata),
    .d_m_hit_o  (hit),
    .d_m_rdata_o(rdata),
    .d_m_err_o  (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model[int];
  int          checks = 0;
  int          passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: every hit must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && hit) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_hit: got hit with no request outstanding (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("hit_cycle", 64'(cyc), 64'(e.cyc));
        chk("rdata", 64'(rdata), 64'(e.rdata));
        chk("err", 64'(err), 64'(e.err));
      end
    end
  end

  // Called right after a posedge with the DUT idle; returns right after the posedge following the hit.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d);
    exp_t        e;
    int          w;
    logic [31:0] v;
    bit          got;
    w       = int'(a / 4);
    e.err   = (a >= 32'(DEPTH * 4));
    e.rdata = '0;
    e.cyc   = cyc + 1 + W;
    if (!e.err) begin
      if (wr) begin
        v = model.exists(w) ? model[w] : 32'h0;
        for (int b = 0; b < 4; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
        model[w] = v;
      end else if (rd) begin
        e.rdata = model[w];
      end
    end
    exp_q.push_back(e);
    addr = a; rden = rd; wren = wr; wmask = m; wdata = d;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (hit) got = 1;
    end
    if (!got) begin
      checks++;
      $display("FAIL hit_timeout: got no hit within 40 cycles, expected hit at cycle %0d", e.cyc);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rden = 1'b0; wren = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hit", 64'(hit), 64'h0);
    chk("reset_rdata", 64'(rdata), 64'h0);
    chk("reset_err", 64'(err), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < WIN; i++) issue(0, 1, 32'(i * 4), 4'hF, $urandom());

    issue(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(1, 0, 32'h10, 4'h0, 32'h0);
    idle(1);

    issue(0, 1, 32'h20, 4'hF, 32'h11223344);
    issue(0, 1, 32'h20, 4'h2, 32'h0000AA00);
    issue(1, 0, 32'h20, 4'h0, 32'h0);

    issue(0, 1, 32'h1000, 4'hF, 32'hFFFFFFFF);
    issue(1, 0, 32'h1000, 4'h0, 32'h0);
    issue(1, 0, 32'h0, 4'h0, 32'h0);
    idle(2);

    // Held request: second transaction starts the cycle after the first hit.
    issue(1, 0, 32'h10, 4'h0, 32'h0);
    issue(1, 0, 32'h10, 4'h0, 32'h0);
    idle(1);

`ifdef DMEM_WAIT_STATES_EN
    addr = 32'h20; wren = 1'b1; rden = 1'b0; wmask = 4'hF; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    wren = 1'b0;
    @(posedge clk); #1;
    issue(1, 0, 32'h20, 4'h0, 32'h0);
`endif

    issue(1, 0, 32'h10, 4'h0, 32'h0);
    addr = 32'h10; wren = 1'b1; rden = 1'b0; wmask = 4'hF; wdata = 32'h12345678;
`ifdef DMEM_WAIT_STATES_EN
    @(posedge clk); #1;
`endif
    rst = 1'b1; wren = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_hit", 64'(hit), 64'h0);
    chk("rst_mid_rdata", 64'(rdata), 64'h0);
    @(posedge clk); #1;
    issue(1, 0, 32'h10, 4'h0, 32'h0);

    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + ($urandom() & 32'h0FFF_FFFF);
      else a = 32'($urandom_range(0, WIN - 1) * 4) | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 3);
      issue(op != 1, op != 0, a, 4'($urandom_range(0, 15)), $urandom());
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    idle(10);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
